// File: rtl/memory_bus_interface.sv
// Sequences single-byte accesses to external async SRAM/ROM with wait states.
// Optional MEMBUS_WAIT_EN adds the ext_wait_n port to stretch the final cycle.
module memory_bus_interface #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] Addr,
    inout  wire  [7:0]  Bus,
    input  logic        mem_rd_n,
    input  logic        mem_wr_n,
    input  logic        rd_bus_n,
    output logic        stall,
    output logic        rd_valid,
    output logic        bus_err,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_dout,
    output logic        ext_dout_en,
    input  logic [7:0]  ext_din,
`ifdef MEMBUS_WAIT_EN
    input  logic        ext_wait_n,
`endif
    output logic        ext_ce_n,
    output logic        ext_oe_n,
    output logic        ext_we_n
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [15:0] addr_d;
    logic [7:0]  dout_d;
    logic        dout_en_d;
    logic        ce_n_d, oe_n_d, we_n_d;
    logic        rd_valid_d, bus_err_d;
    logic        req_ok, req_bad, wait_ok;

`ifdef MEMBUS_WAIT_EN
    assign wait_ok = ext_wait_n;
`else
    assign wait_ok = 1'b1;
`endif

    assign req_ok  = mem_rd_n ^ mem_wr_n;
    assign req_bad = ~mem_rd_n & ~mem_wr_n;

    assign stall = (state_q == ACCESS) | (state_q == IDLE & req_ok);
    assign Bus   = rd_bus_n ? 8'hzz : rd_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        rd_data_d  = rd_data_q;
        addr_d     = ext_addr;
        dout_d     = ext_dout;
        dout_en_d  = ext_dout_en;
        ce_n_d     = ext_ce_n;
        oe_n_d     = ext_oe_n;
        we_n_d     = ext_we_n;
        rd_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d   = ACCESS;
                    cnt_d     = WS4;
                    is_rd_d   = ~mem_rd_n;
                    addr_d    = Addr;
                    ce_n_d    = 1'b0;
                    oe_n_d    = mem_rd_n;
                    we_n_d    = mem_wr_n;
                    dout_en_d = ~mem_wr_n;
                    if (!mem_wr_n)
                        dout_d = Bus;
                end else if (req_bad) begin
                    bus_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    // Release WE one cycle early for data/address hold
                    if (!is_rd_q && cnt_q == 4'd1)
                        we_n_d = 1'b1;
                end else if (wait_ok) begin
                    state_d   = IDLE;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    we_n_d    = 1'b1;
                    dout_en_d = 1'b0;
                    if (is_rd_q) begin
                        rd_data_d  = ext_din;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_rd_q     <= 1'b0;
            rd_data_q   <= 8'h00;
            ext_addr    <= 16'h0000;
            ext_dout    <= 8'h00;
            ext_dout_en <= 1'b0;
            ext_ce_n    <= 1'b1;
            ext_oe_n    <= 1'b1;
            ext_we_n    <= 1'b1;
            rd_valid    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            rd_data_q   <= rd_data_d;
            ext_addr    <= addr_d;
            ext_dout    <= dout_d;
            ext_dout_en <= dout_en_d;
            ext_ce_n    <= ce_n_d;
            ext_oe_n    <= oe_n_d;
            ext_we_n    <= we_n_d;
            rd_valid    <= rd_valid_d;
            bus_err     <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_memory_bus_interface.sv
// Testbench for memory_bus_interface: vector table, corner sequences and
// randomized transactions against a cycle-timeline reference model.
module tb_memory_bus_interface;

    localparam int WS = 2;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] Addr;
    wire  [7:0]  Bus;
    logic [7:0]  bus_drv;
    logic        bus_oe;
    logic        mem_rd_n, mem_wr_n, rd_bus_n;
    logic        stall, rd_valid, bus_err;
    logic [15:0] ext_addr;
    logic [7:0]  ext_dout;
    logic        ext_dout_en;
    logic [7:0]  ext_din;
    logic        ext_wait_n;
    logic        ext_ce_n, ext_oe_n, ext_we_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model_rd;

    assign Bus = bus_oe ? bus_drv : 8'hzz;

    always #5 clock = ~clock;

    memory_bus_interface #(.WAIT_STATES(WS)) dut (
        .clock(clock),
        .clear(clear),
        .Addr(Addr),
        .Bus(Bus),
        .mem_rd_n(mem_rd_n),
        .mem_wr_n(mem_wr_n),
        .rd_bus_n(rd_bus_n),
        .stall(stall),
        .rd_valid(rd_valid),
        .bus_err(bus_err),
        .ext_addr(ext_addr),
        .ext_dout(ext_dout),
        .ext_dout_en(ext_dout_en),
        .ext_din(ext_din),
`ifdef MEMBUS_WAIT_EN
        .ext_wait_n(ext_wait_n),
`endif
        .ext_ce_n(ext_ce_n),
        .ext_oe_n(ext_oe_n),
        .ext_we_n(ext_we_n)
    );

    typedef struct {
        logic        rd_n;
        logic        wr_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          stall_cyc;
        logic        err;
        logic        rdv;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        clear    = 1'b0;
        mem_rd_n = 1'b1;
        mem_wr_n = 1'b1;
        rd_bus_n = 1'b1;
        bus_oe   = 1'b0;
        ext_wait_n = 1'b1;
    endtask

    // kind: 0 read, 1 write, 2 illegal. Expected values come from the
    // access timeline: request at k=0, ACCESS for k=1..WS+1.
    task automatic run_txn(input int kind, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] din);
        int last;
        logic in_acc;
        logic [7:0] exp_bus;
        last = (kind == 2) ? 1 : WS + 2;
        for (int k = 0; k <= last; k++) begin
            idle_in();
            ext_din = (k <= WS + 1) ? din : ~din;
            if (k == 0) begin
                mem_rd_n = (kind == 1);
                mem_wr_n = (kind == 0);
                Addr     = a;
                bus_drv  = wd;
                bus_oe   = (kind != 0);
            end else if (k < last) begin
                mem_rd_n = 1'($urandom);
                mem_wr_n = 1'($urandom);
                Addr     = 16'($urandom);
                bus_drv  = 8'($urandom);
                bus_oe   = 1'b1;
            end else begin
                rd_bus_n = 1'b0;
            end
            @(negedge clock);
            in_acc = (kind != 2) && k >= 1 && k <= WS + 1;
            chk("stall", stall, (kind != 2) && k <= WS + 1);
            chk("ce_n", ext_ce_n, !in_acc);
            chk("oe_n", ext_oe_n, !(in_acc && kind == 0));
            chk("we_n", ext_we_n, !(kind == 1 && k >= 1 && k <= WS));
            chk("dout_en", ext_dout_en, in_acc && kind == 1);
            chk("rd_valid", rd_valid, kind == 0 && k == WS + 2);
            chk("bus_err", bus_err, kind == 2 && k == 1);
            if (in_acc) chk("ext_addr", ext_addr, a);
            if (in_acc && kind == 1) chk("ext_dout", ext_dout, wd);
            if (k == last) begin
                exp_bus = (kind == 0) ? din : model_rd;
                chk("bus_rd", Bus, exp_bus);
                model_rd = exp_bus;
            end
            next_cyc();
        end
        idle_in();
    endtask

    initial begin
        int sc;
        logic es, rs;
        logic [15:0] a1;
        logic [7:0] d1;
        logic [7:0] din_t;

        vt[0] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'hA5, WS + 2, 1'b0, 1'b1};
        vt[1] = '{1'b1, 1'b0, 16'h8000, 8'h5A, 8'h00, WS + 2, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 16'h4444, 8'h33, 8'h00, 0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b1, 16'h7777, 8'h44, 8'h00, 0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h3C, WS + 2, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 8'h00, WS + 2, 1'b0, 1'b0};

        idle_in();
        Addr = 16'h0;
        bus_drv = 8'h0;
        ext_din = 8'h0;
        model_rd = 8'h00;
        clear = 1'b1;
        next_cyc();
        next_cyc();
        clear = 1'b0;
        rd_bus_n = 1'b0;
        @(negedge clock);
        chk("rst_stall", stall, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_ext_addr", ext_addr, 16'h0000);
        chk("rst_ext_dout", ext_dout, 8'h00);
        chk("rst_dout_en", ext_dout_en, 1'b0);
        chk("rst_strobes", {ext_ce_n, ext_oe_n, ext_we_n}, 3'b111);
        chk("rst_bus", Bus, 8'h00);
        next_cyc();
        idle_in();

        foreach (vt[i]) begin
            sc = 0;
            es = 1'b0;
            rs = 1'b0;
            a1 = '0;
            d1 = '0;
            for (int k = 0; k <= WS + 4; k++) begin
                idle_in();
                ext_din = vt[i].din;
                if (k == 0) begin
                    mem_rd_n = vt[i].rd_n;
                    mem_wr_n = vt[i].wr_n;
                    Addr     = vt[i].addr;
                    bus_drv  = vt[i].wdata;
                    bus_oe   = 1'b1;
                end
                @(negedge clock);
                sc += int'(stall);
                es |= bus_err;
                rs |= rd_valid;
                if (k == 1) begin
                    a1 = ext_addr;
                    d1 = ext_dout;
                end
                next_cyc();
            end
            chk($sformatf("vec%0d_stall_cyc", i), sc, vt[i].stall_cyc);
            chk($sformatf("vec%0d_err", i), es, vt[i].err);
            chk($sformatf("vec%0d_rdv", i), rs, vt[i].rdv);
            if (vt[i].stall_cyc > 0)
                chk($sformatf("vec%0d_addr", i), a1, vt[i].addr);
            if (!vt[i].wr_n && vt[i].rd_n)
                chk($sformatf("vec%0d_dout", i), d1, vt[i].wdata);
            if (vt[i].rdv) begin
                idle_in();
                rd_bus_n = 1'b0;
                @(negedge clock);
                chk($sformatf("vec%0d_bus", i), Bus, vt[i].din);
                model_rd = vt[i].din;
                next_cyc();
            end
        end
        idle_in();

        // Back-to-back: write 0x11 to 0x0010, read it in the next IDLE cycle
        for (int k = 0; k <= 2 * WS + 4; k++) begin
            idle_in();
            ext_din = 8'h77;
            Addr = 16'h0010;
            if (k == 0) begin
                mem_wr_n = 1'b0;
                bus_drv  = 8'h11;
                bus_oe   = 1'b1;
            end else if (k == WS + 2) begin
                mem_rd_n = 1'b0;
            end else if (k == 2 * WS + 4) begin
                rd_bus_n = 1'b0;
            end
            @(negedge clock);
            chk("b2b_ce_n", ext_ce_n,
                !((k >= 1 && k <= WS + 1) ||
                  (k >= WS + 3 && k <= 2 * WS + 3)));
            chk("b2b_oe_n", ext_oe_n, !(k >= WS + 3 && k <= 2 * WS + 3));
            chk("b2b_we_n", ext_we_n, !(k >= 1 && k <= WS));
            chk("b2b_stall", stall, k <= 2 * WS + 3);
            chk("b2b_rd_valid", rd_valid, k == 2 * WS + 4);
            if (k == 1) chk("b2b_wdata", ext_dout, 8'h11);
            if (k == WS + 3) chk("b2b_raddr", ext_addr, 16'h0010);
            if (k == 2 * WS + 4) chk("b2b_bus", Bus, 8'h77);
            next_cyc();
        end
        model_rd = 8'h77;
        idle_in();

        // Clear in the second ACCESS cycle of a read; request with clear dropped
        for (int k = 0; k <= 4; k++) begin
            idle_in();
            ext_din = 8'hC3;
            Addr = 16'h2222;
            if (k == 0) mem_rd_n = 1'b0;
            if (k == 2) clear = 1'b1;
            if (k == 3) begin
                clear = 1'b1;
                mem_rd_n = 1'b0;
                rd_bus_n = 1'b0;
            end
            @(negedge clock);
            if (k == 3) begin
                chk("clr_strobes", {ext_ce_n, ext_oe_n, ext_we_n}, 3'b111);
                chk("clr_rd_valid", rd_valid, 1'b0);
                chk("clr_bus", Bus, 8'h00);
                chk("clr_dout_en", ext_dout_en, 1'b0);
            end
            if (k == 4) begin
                chk("clr_drop_ce_n", ext_ce_n, 1'b1);
                chk("clr_drop_stall", stall, 1'b0);
                chk("clr_drop_rdv", rd_valid, 1'b0);
            end
            next_cyc();
        end
        model_rd = 8'h00;
        idle_in();

`ifdef MEMBUS_WAIT_EN
        sc = 0;
        rs = 1'b0;
        for (int k = 0; k <= WS + 6; k++) begin
            idle_in();
            Addr = 16'h0ABC;
            if (k == 0) mem_rd_n = 1'b0;
            ext_wait_n = !(k >= WS + 1 && k <= WS + 3);
            ext_din = (k == WS + 4) ? 8'h99 : 8'hEE;
            if (k == WS + 5) rd_bus_n = 1'b0;
            @(negedge clock);
            sc += int'(stall);
            if (k >= 1 && k <= WS + 4)
                chk("wait_oe_n", ext_oe_n, 1'b0);
            chk("wait_rd_valid", rd_valid, k == WS + 5);
            if (k == WS + 5) chk("wait_bus", Bus, 8'h99);
            next_cyc();
        end
        chk("wait_stall_cyc", sc, WS + 5);
        model_rd = 8'h99;
        idle_in();
`endif

        for (int t = 0; t < 40; t++) begin
            int kind;
            int gap;
            kind = ($urandom_range(0, 9) < 1) ? 2 : int'($urandom_range(0, 1));
            run_txn(kind, 16'($urandom), 8'($urandom), 8'($urandom));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idle_in();
                @(negedge clock);
                chk("gap_stall", stall, 1'b0);
                chk("gap_ce_n", ext_ce_n, 1'b1);
                next_cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
